psk31_bpsk_demod: RTL and testbench
===================================

// Module: psk31_bpsk_demod
// PURPOSE
//  Receive-side companion to the transmit DDS: coherent BPSK31 demodulator.
//  - Mixes offset-binary ADC samples with an internal quadrature NCO (I/Q).
//  - Integrates and dumps I and Q over each symbol period.
//  - Decides each bit from the dot product of consecutive symbol vectors: reversal = 0, no reversal = 1.
//  - Feeds the varicode decoder through a valid/ready handshake.
// PARAMETERS
//  SIN_LUT_FILE   "sine_lut.hex"  256-entry quarter-wave LUT, 16-bit; bits [14:0] = magnitude
//  N_ACCUM        14              NCO phase accumulator width
//  N_TUNING       10              tuning word width, zero-extended into accumulator
//  SYMBOL_SAMPLES 256             samples per symbol (>=2)
//  ACC_W          32              I/Q integrator width; wraps, never saturates
//  DUMP_SHIFT     16              arithmetic right shift applied to dumped I/Q before dot product
//  CD_THRESH      16'd2048        carrier-detect threshold on |I|+|Q| (CARRIER_DETECT_EN only)
// PORTS
//  clk            in   1         clock
//  rst            in   1         asynchronous reset, active-high
//  tuning_word    in   N_TUNING  NCO step per valid sample
//  sample_in      in   10        offset-binary sample (10'h200 = zero)
//  sample_valid   in   1         sample strobe, any rate up to 1 per clk
//  bit_out        out  1         decided bit
//  bit_valid      out  1         bit_out valid; held until accepted
//  bit_ready      in   1         consumer accepts when bit_valid & bit_ready
//  overrun        out  1         1-cycle pulse: pending bit overwritten
//  carrier_detect out  1         only with CARRIER_DETECT_EN
// BEHAVIOUR
//  Reset (async, any cycle): phase, integrators, sample count, prev vector, pipeline cleared.
//   All outputs 0; state = PRIME.
//  NCO
//  - Phase advances by tuning_word on each sample_valid only.
//  - sin: idx = phase[N_ACCUM-3:N_ACCUM-10], inverted when phase[N_ACCUM-2] is set.
//    Magnitude = lut[idx][14:5]; negated when phase[N_ACCUM-1] is set (signed 11-bit).
//  - cos: same lookup at phase + 2^(N_ACCUM-2).
//  - The sample uses the phase before the update.
//  - A tuning_word change applies from the next sample.
//  Pipeline, per valid sample:
//  - S1: register sample (MSB inverted -> signed 10b) and sin/cos refs.
//  - S2: register products, 21b signed.
//  - S3: sign-extend and add into I_acc/Q_acc; sample count++.
//  Dump
//  - On the S3 of sample #SYMBOL_SAMPLES, store (acc + that product) >>> DUMP_SHIFT as I_d/Q_d.
//    Saturate to signed 16b. Integrators restart from zero on the next product.
//  - Count wraps to 0.
//  FSM
//  - PRIME: first dump only loads I_p/Q_p, no bit -> RUN.
//  - RUN: each dump computes dot = I_d*I_p + Q_d*Q_p (33b signed, registered 1 cycle).
//    bit = ~dot[32]; dot == 0 -> 1. Then I_p/Q_p <= I_d/Q_d.
//  Latency: bit_valid rises exactly 5 clk edges after the edge capturing the symbol's last sample_valid.
//  Handshake
//  - bit_out/bit_valid hold until bit_valid & bit_ready.
//  - New decision while pending and not accepted: overwrite bit_out, bit_valid stays 1, overrun pulses.
//  - New decision in the same cycle as acceptance: load new bit, bit_valid stays 1, no overrun.
//  - bit_ready while bit_valid = 0: ignored.
//  Gaps in sample_valid stall nothing except the NCO and sample count.
//  A pipeline in flight completes normally.
// CONFIGURATION
//  CARRIER_DETECT_EN defined:
//  - At each dump, carrier_detect <= (|I_d| + |Q_d| > CD_THRESH).
//  - Resets to 0; held between dumps.
//  Undefined: port absent; no magnitude logic.
// TESTING
//  Sim settings: SYMBOL_SAMPLES=16, tuning_word=1024 (carrier = fs/16), sample_valid every clk.
//  1. Loopback tone, no phase flips, 5 symbols, bit_ready=1
//     -> 4 bits, all 1; none for the first symbol.
//  2. Carrier inverted every symbol boundary -> bits 0,0,0,0.
//  3. Tone at quarter-cycle offset, flip after symbol 2 -> bits 1,0,1.
//     Checks I/Q independence of phase.
//  4. bit_ready=0 across two decisions -> overrun pulses once; bit_out = second bit.
//     bit_ready on a decision cycle -> no overrun.
//  5. sample_valid every 3rd clk -> same bits as case 1.
//     bit_valid exactly 5 clks after the last sample edge.
//  6. rst mid-symbol -> outputs 0 asynchronously.
//     After release, the first full symbol primes only (no bit).
//     CARRIER_DETECT_EN: sample_in=10'h200 -> carrier_detect=0; full-scale tone -> 1.

Source files
------------

// File: rtl/psk31_bpsk_demod.sv
// psk31_bpsk_demod: coherent BPSK31 receiver. It mixes offset-binary samples
// with a quadrature NCO, integrates and dumps I/Q once per symbol, and decides
// each bit from the dot product of consecutive symbol vectors.
// A reversal gives 0 and no reversal gives 1.
// Ports: clk, rst (async, active-high), tuning_word, sample_in, sample_valid,
//        bit_out, bit_valid, bit_ready, overrun, carrier_detect.
//        carrier_detect exists only when CARRIER_DETECT_EN is defined.
// Config: `define CARRIER_DETECT_EN adds the |I|+|Q| carrier detector.
module psk31_bpsk_demod #(
  parameter int N_ACCUM        = 14,
  parameter int N_TUNING       = 10,
  parameter int SYMBOL_SAMPLES = 256,
  parameter int ACC_W          = 32,
  parameter int DUMP_SHIFT     = 16
`ifdef CARRIER_DETECT_EN
  ,
  parameter logic [15:0] CD_THRESH = 16'd2048
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TUNING-1:0] tuning_word,
  input  logic [9:0]          sample_in,
  input  logic                sample_valid,
  output logic                bit_out,
  output logic                bit_valid,
  input  logic                bit_ready,
  output logic                overrun
`ifdef CARRIER_DETECT_EN
  ,
  output logic                carrier_detect
`endif
);

  localparam int CNT_W = (SYMBOL_SAMPLES > 2) ?
                         $clog2(SYMBOL_SAMPLES) : 1;
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-32768);

  // Quarter-wave table, built at elaboration.
  // Entry i holds round(32767 * sin(pi/2 * (i + 0.5) / 256)).
  // The half-step offset makes ~idx the exact mirror of idx.
  // The sine is evaluated with a fixed-point Taylor series (Q30).
  function automatic logic [15:0] lut_val(input int i);
    logic signed [63:0] x;
    logic signed [63:0] term;
    logic signed [63:0] sum;
    logic signed [63:0] den;
    logic signed [63:0] v;
    x = (64'sd3373259426 * 64'(2 * i + 1)) / 64'sd1024;
    sum  = x;
    term = x;
    for (int n = 1; n < 8; n++) begin
      term = -((((term * x) >>> 30) * x) >>> 30);
      den  = 64'(2 * n * (2 * n + 1));
      term = term / den;
      sum  = sum + term;
    end
    v = (sum * 64'sd32767 + (64'sd1 <<< 29)) >>> 30;
    return v[15:0];
  endfunction

  logic [9:0] lut [256];

  for (genvar g = 0; g < 256; g++) begin : g_lut
    localparam logic [15:0] V = lut_val(g);
    assign lut[g] = V[14:5];
  end

  function automatic logic signed [15:0] sat16(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] s;
    s = v >>> DUMP_SHIFT;
    if (s > SMAX)
      return 16'sh7fff;
    else if (s < SMIN)
      return 16'sh8000;
    else
      return s[15:0];
  endfunction

  // NCO
  logic [N_ACCUM-1:0] phase;
  logic [7:0]         raw_idx;
  logic [1:0]         quad_s;
  logic [1:0]         quad_c;
  logic [7:0]         idx_s;
  logic [7:0]         idx_c;
  logic [9:0]         mag_s;
  logic [9:0]         mag_c;
  logic signed [10:0] ref_s;
  logic signed [10:0] ref_c;

  // cos = sin at phase + quarter turn. The quarter turn only touches the
  // two top bits, so the raw index is shared and only the quadrant changes.
  assign raw_idx = phase[N_ACCUM-3:N_ACCUM-10];
  assign quad_s  = phase[N_ACCUM-1:N_ACCUM-2];
  assign quad_c  = quad_s + 2'd1;
  assign idx_s   = quad_s[0] ? ~raw_idx : raw_idx;
  assign idx_c   = quad_c[0] ? ~raw_idx : raw_idx;
  assign mag_s   = lut[idx_s];
  assign mag_c   = lut[idx_c];
  assign ref_s   = quad_s[1] ? -$signed({1'b0, mag_s})
                             :  $signed({1'b0, mag_s});
  assign ref_c   = quad_c[1] ? -$signed({1'b0, mag_c})
                             :  $signed({1'b0, mag_c});

  // Mixer / integrate-and-dump pipeline
  logic               s1_vld;
  logic signed [9:0]  s1_smp;
  logic signed [10:0] s1_sin;
  logic signed [10:0] s1_cos;
  logic               s2_vld;
  logic signed [20:0] p_i;
  logic signed [20:0] p_q;
  logic signed [ACC_W-1:0] i_acc;
  logic signed [ACC_W-1:0] q_acc;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic signed [15:0] dump_i;
  logic signed [15:0] dump_q;
  logic               d_vld;
  logic signed [15:0] i_d;
  logic signed [15:0] q_d;

  assign sum_i  = i_acc + ACC_W'(p_i);
  assign sum_q  = q_acc + ACC_W'(p_q);
  assign last   = (cnt == CNT_W'(SYMBOL_SAMPLES - 1));
  assign dump_i = sat16(sum_i);
  assign dump_q = sat16(sum_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= '0;
      s1_vld <= 1'b0;
      s1_smp <= '0;
      s1_sin <= '0;
      s1_cos <= '0;
      s2_vld <= 1'b0;
      p_i    <= '0;
      p_q    <= '0;
      i_acc  <= '0;
      q_acc  <= '0;
      cnt    <= '0;
      d_vld  <= 1'b0;
      i_d    <= '0;
      q_d    <= '0;
    end else begin
      s1_vld <= sample_valid;
      s2_vld <= s1_vld;
      d_vld  <= 1'b0;
      if (sample_valid) begin
        phase  <= phase + N_ACCUM'(tuning_word);
        s1_smp <= {~sample_in[9], sample_in[8:0]};
        s1_sin <= ref_s;
        s1_cos <= ref_c;
      end
      if (s1_vld) begin
        p_i <= s1_smp * s1_sin;
        p_q <= s1_smp * s1_cos;
      end
      if (s2_vld) begin
        if (last) begin
          i_acc <= '0;
          q_acc <= '0;
          cnt   <= '0;
          i_d   <= dump_i;
          q_d   <= dump_q;
          d_vld <= 1'b1;
        end else begin
          i_acc <= sum_i;
          q_acc <= sum_q;
          cnt   <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef CARRIER_DETECT_EN
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic signed [16:0] e;
    e = {v[15], v};
    return v[15] ? 17'(-e) : 17'(e);
  endfunction

  logic [17:0] cd_mag;

  assign cd_mag = {1'b0, abs17(dump_i)} + {1'b0, abs17(dump_q)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      carrier_detect <= 1'b0;
    else if (s2_vld && last)
      carrier_detect <= (cd_mag > {2'b00, CD_THRESH});
  end
`endif

  // Decision FSM
  typedef enum logic {PRIME, RUN} state_t;

  state_t state;
  state_t state_nx;
  logic   load_prev;
  logic   do_dot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= PRIME;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_prev = 1'b0;
    do_dot    = 1'b0;
    unique case (state)
      PRIME: begin
        if (d_vld) begin
          load_prev = 1'b1;
          state_nx  = RUN;
        end
      end
      RUN: begin
        if (d_vld) begin
          load_prev = 1'b1;
          do_dot    = 1'b1;
        end
      end
      default: state_nx = PRIME;
    endcase
  end

  logic signed [15:0] i_p;
  logic signed [15:0] q_p;
  logic signed [31:0] pp_i;
  logic signed [31:0] pp_q;
  logic               pp_vld;
  logic signed [32:0] dot;
  logic               dot_vld;
  logic               dec_bit;

  // A zero dot product has a clear sign bit, so it also decides 1.
  assign dec_bit = ~dot[32] | (dot == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_p     <= '0;
      q_p     <= '0;
      pp_i    <= '0;
      pp_q    <= '0;
      pp_vld  <= 1'b0;
      dot     <= '0;
      dot_vld <= 1'b0;
    end else begin
      pp_vld  <= do_dot;
      dot_vld <= pp_vld;
      if (do_dot) begin
        pp_i <= i_d * i_p;
        pp_q <= q_d * q_p;
      end
      if (load_prev) begin
        i_p <= i_d;
        q_p <= q_d;
      end
      if (pp_vld)
        dot <= 33'(pp_i) + 33'(pp_q);
    end
  end

  // Output handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (dot_vld) begin
        bit_out   <= dec_bit;
        bit_valid <= 1'b1;
        if (bit_valid && !bit_ready)
          overrun <= 1'b1;
      end else if (bit_valid && bit_ready) begin
        bit_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psk31_bpsk_demod.sv
// tb_psk31_bpsk_demod: directed tests for the BPSK31 demodulator.
// SYMBOL_SAMPLES=16, tuning_word=1024 (carrier fs/16).
module tb_psk31_bpsk_demod;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] tuning_word;
  logic [9:0]  sample_in;
  logic        sample_valid;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        overrun;
`ifdef CARRIER_DETECT_EN
  logic        carrier_detect;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psk31_bpsk_demod #(
    .N_TUNING(11),
    .SYMBOL_SAMPLES(16)
`ifdef CARRIER_DETECT_EN
    ,
    .CD_THRESH(16'd32)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .tuning_word(tuning_word),
    .sample_in(sample_in),
    .sample_valid(sample_valid),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .bit_ready(bit_ready),
    .overrun(overrun)
`ifdef CARRIER_DETECT_EN
    ,
    .carrier_detect(carrier_detect)
`endif
  );

  // 400 * cos(2*pi*k/16), rounded
  int cos_tab [16] = '{400, 370, 283, 153, 0, -153, -283, -370,
                       -400, -370, -283, -153, 0, 153, 283, 370};

  logic got_q [$];
  int   ovr_cnt = 0;

  always @(negedge clk) begin
    if (bit_valid && bit_ready)
      got_q.push_back(bit_out);
    if (overrun)
      ovr_cnt++;
  end

  // mode 0: steady, 1: invert odd symbols, 2: invert symbols >= 2
  function automatic logic [9:0] tone(input int n, input int mode,
                                      input bit quarter);
    int k;
    int v;
    int sym;
    bit inv;
    k   = n % 16;
    sym = n / 16;
    v   = quarter ? cos_tab[(k + 4) % 16] : cos_tab[k];
    inv = (mode == 1) ? (sym % 2 == 1) :
          (mode == 2) ? (sym >= 2) : 1'b0;
    if (inv)
      v = -v;
    return 10'(512 + v);
  endfunction

  task automatic send_range(input int first, input int last,
                            input int mode, input bit quarter,
                            input int period);
    for (int n = first; n <= last; n++) begin
      sample_in    = tone(n, mode, quarter);
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      repeat (period - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    tuning_word  = 11'd1024;
    sample_in    = 10'h200;
    sample_valid = 1'b0;
    bit_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %0b want 0", bit_valid);
    end
    checks++;
    if (bit_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_bit got %0b want 0", bit_out);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun got %0b want 0", overrun);
    end
`ifdef CARRIER_DETECT_EN
    checks++;
    if (carrier_detect !== 1'b0) begin
      errors++;
      $display("FAIL reset_cd got %0b want 0", carrier_detect);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_steady();
    int qb;
    logic got;
    do_reset();
    bit_ready = 1'b1;
    qb = got_q.size();
    send_range(0, 79, 0, 1'b0, 1);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - qb !== 4) begin
      errors++;
      $display("FAIL steady_count got %0d want 4", got_q.size() - qb);
    end
    for (int i = 0; i < 4; i++) begin
      got = (qb + i < got_q.size()) ? got_q[qb + i] : 1'bx;
      checks++;
      if (got !== 1'b1) begin
        errors++;
        $display("FAIL steady_bit%0d got %0b want 1", i, got);
      end
    end
  endtask

  task automatic test_reversals();
    int qb;
    logic got;
    do_reset();
    bit_ready = 1'b1;
    qb = got_q.size();
    send_range(0, 79, 1, 1'b0, 1);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - qb !== 4) begin
      errors++;
      $display("FAIL rev_count got %0d want 4", got_q.size() - qb);
    end
    for (int i = 0; i < 4; i++) begin
      got = (qb + i < got_q.size()) ? got_q[qb + i] : 1'bx;
      checks++;
      if (got !== 1'b0) begin
        errors++;
        $display("FAIL rev_bit%0d got %0b want 0", i, got);
      end
    end
  endtask

  task automatic test_quarter();
    int qb;
    logic got;
    logic exp3 [3];
    exp3 = '{1'b1, 1'b0, 1'b1};
    do_reset();
    bit_ready = 1'b1;
    qb = got_q.size();
    send_range(0, 63, 2, 1'b1, 1);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - qb !== 3) begin
      errors++;
      $display("FAIL quarter_count got %0d want 3", got_q.size() - qb);
    end
    for (int i = 0; i < 3; i++) begin
      got = (qb + i < got_q.size()) ? got_q[qb + i] : 1'bx;
      checks++;
      if (got !== exp3[i]) begin
        errors++;
        $display("FAIL quarter_bit%0d got %0b want %0b", i, got, exp3[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int ob;
    do_reset();
    bit_ready = 1'b0;
    ob = ovr_cnt;
    send_range(0, 47, 2, 1'b0, 1);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ovr_cnt - ob !== 1) begin
      errors++;
      $display("FAIL ovr_pulses got %0d want 1", ovr_cnt - ob);
    end
    checks++;
    if (bit_out !== 1'b0) begin
      errors++;
      $display("FAIL ovr_bit got %0b want 0", bit_out);
    end
    checks++;
    if (bit_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_valid got %0b want 1", bit_valid);
    end
    send_range(48, 63, 2, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    bit_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL accept_ovr got %0b want 0", overrun);
    end
    checks++;
    if (bit_valid !== 1'b1) begin
      errors++;
      $display("FAIL accept_valid got %0b want 1", bit_valid);
    end
    checks++;
    if (bit_out !== 1'b1) begin
      errors++;
      $display("FAIL accept_bit got %0b want 1", bit_out);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovr_cnt - ob !== 1) begin
      errors++;
      $display("FAIL accept_pulses got %0d want 1", ovr_cnt - ob);
    end
  endtask

  task automatic test_gaps();
    int qb;
    int lat;
    logic got;
    do_reset();
    bit_ready = 1'b1;
    qb  = got_q.size();
    lat = 0;
    send_range(0, 78, 0, 1'b0, 3);
    send_range(79, 79, 0, 1'b0, 1);
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (bit_valid && lat == 0)
        lat = e;
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL gap_latency got %0d want 5", lat);
    end
    checks++;
    if (got_q.size() - qb !== 4) begin
      errors++;
      $display("FAIL gap_count got %0d want 4", got_q.size() - qb);
    end
    for (int i = 0; i < 4; i++) begin
      got = (qb + i < got_q.size()) ? got_q[qb + i] : 1'bx;
      checks++;
      if (got !== 1'b1) begin
        errors++;
        $display("FAIL gap_bit%0d got %0b want 1", i, got);
      end
    end
  endtask

  task automatic test_mid_reset();
    int qb;
    logic got;
    do_reset();
    bit_ready = 1'b0;
    send_range(0, 39, 0, 1'b0, 1);
    checks++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got %0b%0b want 11", bit_valid, bit_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bit_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_valid got %0b want 0", bit_valid);
    end
    checks++;
    if (bit_out !== 1'b0) begin
      errors++;
      $display("FAIL async_bit got %0b want 0", bit_out);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bit_ready = 1'b1;
    qb = got_q.size();
    send_range(0, 15, 0, 1'b0, 1);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - qb !== 0) begin
      errors++;
      $display("FAIL prime_count got %0d want 0", got_q.size() - qb);
    end
    send_range(16, 31, 0, 1'b0, 1);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - qb !== 1) begin
      errors++;
      $display("FAIL after_count got %0d want 1", got_q.size() - qb);
    end
    got = (qb < got_q.size()) ? got_q[qb] : 1'bx;
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL after_bit got %0b want 1", got);
    end
  endtask

`ifdef CARRIER_DETECT_EN
  task automatic test_carrier_detect();
    do_reset();
    bit_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      sample_in    = 10'h200;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    sample_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (carrier_detect !== 1'b0) begin
      errors++;
      $display("FAIL cd_quiet got %0b want 0", carrier_detect);
    end
    send_range(16, 31, 0, 1'b0, 1);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (carrier_detect !== 1'b1) begin
      errors++;
      $display("FAIL cd_tone got %0b want 1", carrier_detect);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_steady();
    test_reversals();
    test_quarter();
    test_overrun();
    test_gaps();
    test_mid_reset();
`ifdef CARRIER_DETECT_EN
    test_carrier_detect();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
